// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the instruction/data memory arbiter.
package mem_arb_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_t;

    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_IF) ? OWN_D : OWN_IF;
    endfunction
endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch and data ports.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic pointer,
    output logic owner
);
    // pointer breaks ties only; a lone requester always wins
    always_comb begin
        owner = OWN_D;
        if (if_req && d_req) begin
            owner = pointer;
        end else if (if_req) begin
            owner = OWN_IF;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) single-memory arbiter: IDLE -> ACCESS -> RESP per transaction.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed data priority.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              halt_sys,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              mem_halt,
    output logic              busy
);
    state_t            state_reg;
    owner_t            owner_reg;
    logic              if_ack_reg;
    logic              d_ack_reg;
    logic [DATA_W-1:0] if_rdata_reg;
    logic [DATA_W-1:0] d_rdata_reg;
    logic              mem_write_en_reg;
    logic [ADDR_W-1:0] mem_address_reg;
    logic [DATA_W-1:0] mem_write_data_reg;

    logic   pick_owner;
    logic   pointer;
    owner_t winner;
    logic   grant;
    logic   win_store;

    assign grant     = (state_reg == IDLE) && !halt_sys && (if_req || d_req);
    assign winner    = owner_t'(pick_owner);
    assign win_store = (winner == OWN_D) && d_we;

    mem_arb_pick u_pick (
        .if_req  (if_req),
        .d_req   (d_req),
        .pointer (pointer),
        .owner   (pick_owner)
    );

`ifdef MEM_ARB_RR_EN
    owner_t pointer_reg;

    // Favour whichever port lost the most recent grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pointer_reg <= OWN_D;
        end else if (grant) begin
            pointer_reg <= other_owner(winner);
        end
    end
    assign pointer = pointer_reg;
`else
    assign pointer = OWN_D;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg          <= IDLE;
            owner_reg          <= OWN_IF;
            if_ack_reg         <= 1'b0;
            d_ack_reg          <= 1'b0;
            if_rdata_reg       <= '0;
            d_rdata_reg        <= '0;
            mem_write_en_reg   <= 1'b0;
            mem_address_reg    <= '0;
            mem_write_data_reg <= '0;
        end else begin
            if_ack_reg <= 1'b0;
            d_ack_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant) begin
                        owner_reg        <= winner;
                        mem_address_reg  <= (winner == OWN_D) ? d_addr : if_addr;
                        mem_write_en_reg <= win_store;
                        if (win_store) begin
                            mem_write_data_reg <= d_wdata;
                        end
                        state_reg <= ACCESS;
                    end
                end
                ACCESS: begin
                    // mem_write_en_reg still holds the latched store flag here
                    mem_write_en_reg <= 1'b0;
                    if (!mem_write_en_reg) begin
                        if (owner_reg == OWN_D) begin
                            d_rdata_reg <= mem_data_out;
                        end else begin
                            if_rdata_reg <= mem_data_out;
                        end
                    end
                    if (owner_reg == OWN_D) begin
                        d_ack_reg <= 1'b1;
                    end else begin
                        if_ack_reg <= 1'b1;
                    end
                    state_reg <= RESP;
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign if_ack         = if_ack_reg;
    assign d_ack          = d_ack_reg;
    assign if_rdata       = if_rdata_reg;
    assign d_rdata        = d_rdata_reg;
    assign mem_write_en   = mem_write_en_reg;
    assign mem_address    = mem_address_reg;
    assign mem_write_data = mem_write_data_reg;
    assign busy           = (state_reg != IDLE);
    assign mem_halt       = halt_sys && (state_reg == IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions, monitor checks every ack.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt_sys = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        mem_write_en;
    logic [15:0] mem_address;
    logic [15:0] mem_write_data;
    logic [15:0] mem_data_out;
    logic        mem_halt;
    logic        busy;

    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = '0;
    logic [15:0] pre_data = '0;
    bit   [15:0] mem [0:65535];

    typedef struct {
        logic        is_d;
        logic [15:0] data;
        logic        chk_data;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    int checks = 0;
    int failures = 0;
    int d_ack_cnt = 0;
    int if_ack_cnt = 0;
    int we_cycles = 0;

    mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .halt_sys       (halt_sys),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_ack         (if_ack),
        .if_rdata       (if_rdata),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_ack          (d_ack),
        .d_rdata        (d_rdata),
        .mem_write_en   (mem_write_en),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_data_out   (mem_data_out),
        .mem_halt       (mem_halt),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    assign mem_data_out = mem[mem_address];

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (mem_write_en) mem[mem_address] <= mem_write_data;
    end

    // Monitor: pops one expectation per ack, flags acks nobody asked for.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_write_en) we_cycles++;
            if (if_ack && d_ack) begin
                checks++;
                failures++;
                $display("FAIL dual_ack actual=if_ack&d_ack required=one_ack");
            end else if (if_ack || d_ack) begin
                if (d_ack) d_ack_cnt++; else if_ack_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_ack actual=%s_ack required=none", d_ack ? "d" : "if");
                end else begin
                    mon_e = sb.pop_front();
                    if (d_ack !== mon_e.is_d) begin
                        failures++;
                        $display("FAIL ack_port actual=%s required=%s",
                                 d_ack ? "d" : "if", mon_e.is_d ? "d" : "if");
                    end else if (mon_e.chk_data && ((d_ack ? d_rdata : if_rdata) !== mon_e.data)) begin
                        failures++;
                        $display("FAIL ack_data actual=%h required=%h",
                                 d_ack ? d_rdata : if_rdata, mon_e.data);
                    end
                    $display("txn %s_ack rdata=%h t=%0t", d_ack ? "d" : "if",
                             d_ack ? d_rdata : if_rdata, $time);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ifack"}, {31'b0, if_ack}, 0);
        check({tag, "_dack"}, {31'b0, d_ack}, 0);
        check({tag, "_ifrdata"}, {16'b0, if_rdata}, 0);
        check({tag, "_drdata"}, {16'b0, d_rdata}, 0);
        check({tag, "_we"}, {31'b0, mem_write_en}, 0);
        check({tag, "_addr"}, {16'b0, mem_address}, 0);
        check({tag, "_wdata"}, {16'b0, mem_write_data}, 0);
        check({tag, "_busy"}, {31'b0, busy}, 0);
    endtask

    // Issue one transaction from IDLE; expects ack two edges after sampling.
    task automatic run_txn(input bit is_d, input bit we, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [15:0] exp_data);
        int n;
        int we0;
        bit got;
        exp_t e;
        e.is_d = is_d;
        e.data = exp_data;
        e.chk_data = !(is_d && we);
        sb.push_back(e);
        we0 = we_cycles;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        n = 0;
        got = 1'b0;
        while (n < 10 && !got) begin
            tick();
            n++;
            if (is_d ? d_ack : if_ack) got = 1'b1;
        end
        check(is_d ? "d_latency" : "if_latency", n, 2);
        d_req = 1'b0;
        if_req = 1'b0;
        tick();
        check("we_cycles", we_cycles - we0, (is_d && we) ? 1 : 0);
        check("idle_busy", {31'b0, busy}, 0);
    endtask

    initial begin
        int d0;
        int i0;
        exp_t e;
        int wait_n;

        // Reset state and memory preload.
        pre_we = 1'b1; pre_addr = 16'h0040; pre_data = 16'hBEEF;
        tick();
        pre_we = 1'b0;
        check_all_zero("reset");
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("no_grant_without_req", {31'b0, busy}, 0);
        check("mem_halt_low", {31'b0, mem_halt}, 0);

        // Single load, store, load-back, fetch, held rdata.
        run_txn(1'b1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF);
        run_txn(1'b1, 1'b1, 16'h0100, 16'h1234, 16'h0000);
        check("d_rdata_hold_store", {16'b0, d_rdata}, 32'hBEEF);
        run_txn(1'b1, 1'b0, 16'h0100, 16'h0000, 16'h1234);
        run_txn(1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF);
        check("d_rdata_hold_fetch", {16'b0, d_rdata}, 32'h1234);
        run_txn(1'b1, 1'b1, 16'h0104, 16'h7777, 16'h0000);
        check("if_rdata_hold", {16'b0, if_rdata}, 32'hBEEF);
        check("d_rdata_hold_store2", {16'b0, d_rdata}, 32'h1234);

        // Halt raised during a store's ACCESS cycle.
        e.is_d = 1'b1; e.data = 16'h0000; e.chk_data = 1'b0;
        sb.push_back(e);
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h5555;
        tick();
        halt_sys = 1'b1;
        #1;
        check("halt_access_we", {31'b0, mem_write_en}, 1);
        check("halt_access_memhalt", {31'b0, mem_halt}, 0);
        tick();
        check("halt_store_ack", {31'b0, d_ack}, 1);
        check("halt_resp_memhalt", {31'b0, mem_halt}, 0);
        d_we = 1'b0;
        tick();
        check("halt_idle_memhalt", {31'b0, mem_halt}, 1);
        repeat (4) begin
            tick();
            check("halt_no_grant", {31'b0, busy}, 0);
        end
        check("halt_store_written", {16'b0, mem[16'h0200]}, 32'h5555);
        e.is_d = 1'b1; e.data = 16'h5555; e.chk_data = 1'b1;
        sb.push_back(e);
        halt_sys = 1'b0;
        tick();
        check("halt_resume_grant", {31'b0, busy}, 1);
        tick();
        check("halt_resume_ack", {31'b0, d_ack}, 1);
        d_req = 1'b0;
        tick();

        // Reset during a store's ACCESS cycle.
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0300; d_wdata = 16'hAAAA;
        tick();
        check("rst_pre_we", {31'b0, mem_write_en}, 1);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        d_req = 1'b0;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("rst_no_write", {16'b0, mem[16'h0300]}, 0);
        check("rst_idle_busy", {31'b0, busy}, 0);

        // Contention for 12 cycles straight after reset.
        d0 = d_ack_cnt;
        i0 = if_ack_cnt;
`ifdef MEM_ARB_RR_EN
        for (int k = 0; k < 4; k++) begin
            e.is_d = (k % 2 == 0);
            e.data = e.is_d ? 16'hBEEF : 16'h1234;
            e.chk_data = 1'b1;
            sb.push_back(e);
        end
`else
        for (int k = 0; k < 4; k++) begin
            e.is_d = 1'b1; e.data = 16'hBEEF; e.chk_data = 1'b1;
            sb.push_back(e);
        end
`endif
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
        if_req = 1'b1; if_addr = 16'h0100;
        repeat (12) tick();
        d_req = 1'b0;
        if_req = 1'b0;
        repeat (3) tick();
`ifdef MEM_ARB_RR_EN
        check("contend_d_acks", d_ack_cnt - d0, 2);
        check("contend_if_acks", if_ack_cnt - i0, 2);
`else
        check("contend_d_acks", d_ack_cnt - d0, 4);
        check("contend_if_acks", if_ack_cnt - i0, 0);
`endif

        wait_n = 0;
        while (sb.size() != 0 && wait_n < 20) begin
            tick();
            wait_n++;
        end
        check("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
